// File: rtl/tm_pkg.sv
// Shared types for the Turing machine memory path: requester ownership and arbiter FSM states.
package tm_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tape_mem_arbiter_starve_counter.sv
// Saturating up-counter with clear; sat flags that the count has reached MAX_COUNT.
module starve_counter #(
    parameter int unsigned MAX_COUNT = 4,
    parameter int unsigned CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CW-1:0] MaxVal = CW'(MAX_COUNT);

    logic [CW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MaxVal)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sat = (count_q == MaxVal);

endmodule

// File: rtl/tape_mem_arbiter.sv
// Shares the single-port working memory between the core FSM and the debug port, with a
// starvation boost for dbg, a core lock for read-modify-write, and tagged read returns.
module tape_mem_arbiter
    import tm_pkg::*;
#(
    parameter int unsigned DW       = 4,
    parameter int unsigned W        = 64,
    parameter int unsigned AW       = $clog2(W),
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic          core_lock,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    arb_state_t state_q, state_d;
    owner_t     tag_q, tag_d, win;
    logic       arb_mode, wait_sat, core_win, dbg_win;

    // The cycle the core drops its lock is arbitrated normally, boost included.
    assign arb_mode = (state_q == ARB) || !core_lock;

    always_comb begin
        core_win = 1'b0;
        dbg_win  = 1'b0;
        if (reset_n) begin
            if (!arb_mode) begin
                core_win = core_req;
            end else if (wait_sat && dbg_req) begin
                dbg_win = 1'b1;
            end else begin
                core_win = core_req;
                dbg_win  = dbg_req && !core_req;
            end
        end
    end

    always_comb begin
        win       = OWN_NONE;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_win) begin
            win       = OWN_CORE;
            mem_we    = core_we;
            mem_re    = !core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dbg_win) begin
            win       = OWN_DBG;
            mem_we    = dbg_we;
            mem_re    = !dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_comb begin
        state_d = LOCKED;
        if (arb_mode) begin
            state_d = (core_win && core_lock) ? LOCKED : ARB;
        end
        tag_d = mem_re ? win : OWN_NONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB;
            tag_q   <= OWN_NONE;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    starve_counter #(
        .MAX_COUNT(MAX_WAIT)
    ) u_starve_counter (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (dbg_req && !dbg_win),
        .clr    (dbg_win || !dbg_req),
        .sat    (wait_sat)
    );

    assign core_gnt    = core_win;
    assign dbg_gnt     = dbg_win;
    assign owner       = win;
    assign core_rvalid = (tag_q == OWN_CORE);
    assign dbg_rvalid  = (tag_q == OWN_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dbg_rdata   = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Bench for tape_mem_arbiter: vector table, directed corner sequences and random traffic
// against a cycle-level reference model with its own shadow memory.
module tb_tape_mem_arbiter;

    localparam int unsigned DW = 4;
    localparam int unsigned W = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned MAX_WAIT = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic core_req, core_we, core_lock, dbg_req, dbg_we;
    logic [AW-1:0] core_addr, dbg_addr;
    logic [DW-1:0] core_wdata, dbg_wdata;
    logic core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, mem_re, mem_we;
    logic [DW-1:0] core_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0] owner;

    logic [DW-1:0] mem [W];
    logic [DW-1:0] ref_mem [W];

    int n_checks;
    int n_errors;

    // Reference model state
    bit m_locked;
    int m_wait;
    int m_tag;
    logic [DW-1:0] m_rdata;
    bit m_cg, m_dg;

    // Snapshot of DUT outputs at the last step's sample point
    logic s_cg, s_dg, s_crv, s_drv, s_mwe;
    logic [1:0] s_own;
    logic [DW-1:0] s_crd, s_drd;

    typedef struct {
        bit creq, cwe, lck;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        bit dreq, dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        bit ecg, edg;
        logic [1:0] eown;
    } vec_t;

    vec_t vecs[$];

    tape_mem_arbiter #(
        .DW(DW), .W(W), .AW(AW), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 5) return 4'hA;
        if (i == 3) return 4'h1;
        if (i == 60) return 4'h7;
        return DW'((i * 7 + 3) % 16);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < W; i++) mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    function automatic logic [25:0] pack_out();
        return {core_gnt, dbg_gnt, owner, mem_re, mem_we, mem_addr, mem_wdata,
                core_rvalid, core_rdata, dbg_rvalid, dbg_rdata};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_wait = 0;
        m_tag = 0;
        m_rdata = '0;
        for (int i = 0; i < W; i++) ref_mem[i] = init_word(i);
    endtask

    // Expected outputs from the pre-cycle model state, then advance the model one cycle.
    task automatic model_cycle(output logic [25:0] exp);
        bit arb;
        logic we, re, crv, drv;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, crd, drd;
        logic [1:0] own;
        arb = !m_locked || !core_lock;
        m_cg = 0;
        m_dg = 0;
        if (!arb) m_cg = core_req;
        else if (m_wait == MAX_WAIT && dbg_req) m_dg = 1;
        else begin
            m_cg = core_req;
            m_dg = dbg_req && !core_req;
        end
        own = m_cg ? 2'd1 : (m_dg ? 2'd2 : 2'd0);
        we = m_cg ? core_we : (m_dg ? dbg_we : 1'b0);
        re = (m_cg || m_dg) && !we;
        a = m_cg ? core_addr : (m_dg ? dbg_addr : '0);
        wd = m_cg ? core_wdata : (m_dg ? dbg_wdata : '0);
        crv = (m_tag == 1);
        drv = (m_tag == 2);
        crd = crv ? m_rdata : '0;
        drd = drv ? m_rdata : '0;
        exp = {m_cg, m_dg, own, re, we, a, wd, crv, crd, drv, drd};
        m_locked = arb ? (m_cg && core_lock) : 1'b1;
        m_wait = (m_dg || !dbg_req) ? 0 : ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT);
        m_tag = 0;
        if (m_cg || m_dg) begin
            if (we) ref_mem[a] = wd;
            else begin
                m_tag = m_cg ? 1 : 2;
                m_rdata = ref_mem[a];
            end
        end
    endtask

    task automatic step(input string name, input bit rst_mid = 0);
        logic [25:0] exp;
        @(negedge clock);
        model_cycle(exp);
        {s_cg, s_dg, s_own} = {core_gnt, dbg_gnt, owner};
        {s_crv, s_crd, s_drv, s_drd, s_mwe} = {core_rvalid, core_rdata, dbg_rvalid, dbg_rdata, mem_we};
        check(name, 32'(pack_out()), 32'(exp));
        if (rst_mid) begin
            #1 reset_n = 1'b0;
            model_reset();
        end
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(bit creq, bit cwe, bit lck, int caddr, int cwd, bit dreq,
                                bit dwe, int daddr, int dwd, bit ecg, bit edg, int eown);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.lck = lck; v.caddr = AW'(caddr); v.cwd = DW'(cwd);
        v.dreq = dreq; v.dwe = dwe; v.daddr = AW'(daddr); v.dwd = DW'(dwd);
        v.ecg = ecg; v.edg = edg; v.eown = 2'(eown);
        return v;
    endfunction

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_lock = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    initial begin
        bit c_pend, d_pend;
        logic [25:0] zero_exp;
        n_checks = 0;
        n_errors = 0;
        zero_exp = '0;
        idle_inputs();
        model_reset();

        // Outputs stay zero under reset even with both requests up
        core_req = 1; dbg_req = 1; dbg_addr = 6'd9;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 32'(pack_out()), 32'(zero_exp));
        idle_inputs();
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Core read of addr 5 returns 4'hA one cycle later
        core_req = 1; core_addr = 6'd5;
        step("core_rd5_grant");
        check("core_rd5_gnt", 32'(s_cg), 32'd1);
        idle_inputs();
        step("core_rd5_resp");
        check("core_rd5_data", {27'd0, s_crv, s_crd}, {27'd0, 1'b1, 4'hA});

        // Contention, lock hold/release, dbg write then core readback
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 2, 0, (i % 5) != 4, (i % 5) == 4,
                              ((i % 5) == 4) ? 2 : 1));
        for (int i = 0; i < 11; i++) vecs.push_back(mk(1, 0, 1, 7, 0, 1, 0, 8, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 7, 0, 1, 0, 8, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 20, 15, 0, 1, 2));
        vecs.push_back(mk(1, 0, 0, 20, 0, 0, 0, 0, 0, 1, 0, 1));
        foreach (vecs[i]) begin
            core_req = vecs[i].creq; core_we = vecs[i].cwe; core_lock = vecs[i].lck;
            core_addr = vecs[i].caddr; core_wdata = vecs[i].cwd;
            dbg_req = vecs[i].dreq; dbg_we = vecs[i].dwe;
            dbg_addr = vecs[i].daddr; dbg_wdata = vecs[i].dwd;
            step($sformatf("vec%0d_model", i));
            check($sformatf("vec%0d_gnt", i), {28'd0, s_cg, s_dg, s_own},
                  {28'd0, vecs[i].ecg, vecs[i].edg, vecs[i].eown});
        end
        idle_inputs();
        step("rd20_resp");
        check("rd20_data", {27'd0, s_crv, s_crd}, {27'd0, 1'b1, 4'hF});

        // Tagging across owner change
        core_req = 1; core_addr = 6'd3;
        step("tag_core");
        idle_inputs();
        dbg_req = 1; dbg_addr = 6'd60;
        step("tag_dbg");
        check("tag_core_resp", {22'd0, s_crv, s_crd, s_drv, s_drd}, {22'd0, 1'b1, 4'h1, 1'b0, 4'h0});
        idle_inputs();
        step("tag_idle");
        check("tag_dbg_resp", {22'd0, s_crv, s_crd, s_drv, s_drd}, {22'd0, 1'b0, 4'h0, 1'b1, 4'h7});

        // Reset between a dbg read grant and its response
        dbg_req = 1; dbg_addr = 6'd60;
        step("mr_grant", 1);
        @(negedge clock);
        check("mr_in_reset", 32'(pack_out()), 32'(zero_exp));
        idle_inputs();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        step("mr_after");
        check("mr_no_rvalid", 32'(s_drv), 32'd0);
        core_lock = 1; dbg_req = 1; dbg_addr = 6'd11;
        step("mr_state_arb");
        check("mr_dbg_gnt", 32'(s_dg), 32'd1);
        idle_inputs();
        step("mr_idle");

        // Random traffic; ungranted requests hold their operands
        c_pend = 0;
        d_pend = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!c_pend && $urandom_range(0, 9) < 6) begin
                c_pend = 1;
                core_we = $urandom_range(0, 2) == 0;
                core_addr = AW'($urandom_range(0, W - 1));
                core_wdata = DW'($urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 9) < 5) begin
                d_pend = 1;
                dbg_we = $urandom_range(0, 3) == 0;
                dbg_addr = AW'($urandom_range(0, W - 1));
                dbg_wdata = DW'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 9) < 2) core_lock = ~core_lock;
            core_req = c_pend;
            dbg_req = d_pend;
            step("rand");
            if (m_cg) c_pend = 0;
            if (m_dg) d_pend = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
